// File: rtl/disp_scan_pkg.sv
// Shared constants for the 6-digit 7-segment scanner: glyphs, dp placement, FSM states.
package disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-high glyphs, bit order g..a.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Separators after minutes (digit 4) and after seconds (digit 2).
    localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

    typedef enum logic {BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/disp_scan_seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment glyph; non-decimal nibbles show a dash.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    always_comb begin
        // NOTE: the default arm covers every unlisted (and X) value, so no latch is inferred.
        unique case (bcd)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed 6-digit 7-segment scanner with per-frame snapshot and inter-slot blanking.
// Optional leading-zero blanking of the minute digits when DISP_SCAN_LZB_EN is defined.
module disp_scan
    import disp_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYC      = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic        clk_50Mhz,
    input  logic        rst,
    input  logic [23:0] dispbuf,
    output logic [7:0]  seg,
    output logic [5:0]  sel,
    output logic        frame_tick
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [7:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [5:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    generate
        if (DIV < 4) begin : g_bad_div
            $error("disp_scan: CLK_HZ/SCAN_HZ must be at least 4");
        end
        if (BLANK_CYC < 1 || BLANK_CYC >= DIV) begin : g_bad_blank
            $error("disp_scan: BLANK_CYC must satisfy 1 <= BLANK_CYC < DIV");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [23:0]      snap;
    scan_state_t      state;

    logic       slot_end;
    logic       frame_start;
    logic [3:0] cur_digit;
    logic [6:0] glyph;
    logic       lzb_blank;
    logic       lit;
    logic [7:0] seg_hi;
    logic [5:0] sel_hi;
    logic [7:0] seg_nxt;
    logic [5:0] sel_nxt;

    assign slot_end    = (cnt == CNT_W'(DIV - 1));
    assign frame_start = (cnt == '0) && (idx == 3'd0);
    assign cur_digit   = snap[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .bcd   (cur_digit),
        .glyph (glyph)
    );

`ifdef DISP_SCAN_LZB_EN
    // Digit 4 blanks only when digit 5 is also zero, so "05:xx" keeps its leading 5.
    assign lzb_blank = ((idx == 3'd5) && (snap[23:20] == 4'd0)) ||
                       ((idx == 3'd4) && (snap[23:16] == 8'd0));
`else
    assign lzb_blank = 1'b0;
`endif

    always_comb begin
        lit     = (state == SHOW) && !lzb_blank;
        seg_hi  = lit ? {DP_MASK[idx], glyph} : {1'b0, SEG_OFF};
        sel_hi  = lit ? (6'd1 << idx) : 6'd0;
        seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        sel_nxt = (SEL_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
    end

    // state tracks the current cnt (BLANK below BLANK_CYC); pins follow one cycle later.
    always_ff @(posedge clk_50Mhz) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            cnt        <= '0;
            idx        <= 3'd0;
            state      <= BLANK;
            snap       <= 24'h0;
            frame_tick <= 1'b0;
            sel        <= SEL_IDLE;
            seg        <= SEG_IDLE;
        end else begin
            frame_tick <= frame_start;
            if (frame_start) begin
                snap <= dispbuf;
            end

            if (slot_end) begin
                cnt   <= '0;
                idx   <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
                state <= BLANK;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(BLANK_CYC - 1)) begin
                    state <= SHOW;
                end
            end

            sel <= sel_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan at DIV=10, BLANK_CYC=2, both polarities active-low.
// Expected values for slots 4/5 of the zero-leading vectors follow DISP_SCAN_LZB_EN.
module tb_disp_scan;

    logic        clk_50Mhz = 1'b0;
    logic        rst       = 1'b1;
    logic [23:0] dispbuf   = 24'h0;
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic        frame_tick;

    disp_scan #(
        .CLK_HZ         (100),
        .SCAN_HZ        (10),
        .BLANK_CYC      (2),
        .SEG_ACTIVE_LOW (1),
        .SEL_ACTIVE_LOW (1)
    ) dut (
        .clk_50Mhz  (clk_50Mhz),
        .rst        (rst),
        .dispbuf    (dispbuf),
        .seg        (seg),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    typedef struct {
        logic [23:0] dbuf;
        int          slot;
        logic [5:0]  exp_sel;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cur    = -1;   // posedges seen since reset release, 0 = first edge with rst low

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, n_cur);
    endtask

    task automatic start(input logic [23:0] d);
        dispbuf = d;
        rst     = 1'b1;
        repeat (3) @(posedge clk_50Mhz);
        #1;
        rst   = 1'b0;
        n_cur = -1;
    endtask

    task automatic go_to(input int n);
        while (n_cur < n) begin
            @(posedge clk_50Mhz);
            #1;
            n_cur++;
        end
    endtask

    initial begin
        int first;

        // Hand-computed: seg = ~({dp, glyph}), sel = ~(1 << slot).
        vecs.push_back('{24'h123456, 0, 6'h3E, 8'h82});
        vecs.push_back('{24'h123456, 1, 6'h3D, 8'h92});
        vecs.push_back('{24'h123456, 2, 6'h3B, 8'h19});
        vecs.push_back('{24'h123456, 3, 6'h37, 8'hB0});
        vecs.push_back('{24'h123456, 4, 6'h2F, 8'h24});
        vecs.push_back('{24'h123456, 5, 6'h1F, 8'hF9});
        vecs.push_back('{24'hA0B0C0, 0, 6'h3E, 8'hC0});
        vecs.push_back('{24'hA0B0C0, 1, 6'h3D, 8'hBF});
        vecs.push_back('{24'hA0B0C0, 3, 6'h37, 8'hBF});
        vecs.push_back('{24'hA0B0C0, 4, 6'h2F, 8'h40});
        vecs.push_back('{24'hA0B0C0, 5, 6'h1F, 8'hBF});
        vecs.push_back('{24'h789000, 3, 6'h37, 8'h90});
        vecs.push_back('{24'h789000, 4, 6'h2F, 8'h00});
        vecs.push_back('{24'h789000, 5, 6'h1F, 8'hF8});
        vecs.push_back('{24'h000512, 0, 6'h3E, 8'hA4});
        vecs.push_back('{24'h000512, 2, 6'h3B, 8'h12});
        vecs.push_back('{24'h050512, 4, 6'h2F, 8'h12});
`ifdef DISP_SCAN_LZB_EN
        vecs.push_back('{24'h000512, 4, 6'h3F, 8'hFF});
        vecs.push_back('{24'h000512, 5, 6'h3F, 8'hFF});
        vecs.push_back('{24'h050512, 5, 6'h3F, 8'hFF});
`else
        vecs.push_back('{24'h000512, 4, 6'h2F, 8'h40});
        vecs.push_back('{24'h000512, 5, 6'h1F, 8'hC0});
        vecs.push_back('{24'h050512, 5, 6'h1F, 8'hC0});
`endif

        // Reset state, first frame_tick, frame period.
        rst = 1'b1;
        repeat (3) @(posedge clk_50Mhz);
        #1;
        check("reset_sel", sel, 6'h3F);
        check("reset_seg", seg, 8'hFF);
        check("reset_tick", frame_tick, 1'b0);
        rst   = 1'b0;
        n_cur = -1;
        go_to(0);
        check("first_tick", frame_tick, 1'b1);
        go_to(1);
        check("tick_one_cycle", frame_tick, 1'b0);
        first = -1;
        while (n_cur < 200 && first < 0) begin
            go_to(n_cur + 1);
            if (frame_tick === 1'b1) first = n_cur;
        end
        check("frame_period", first, 60);

        // Per-slot blank, first lit cycle and last lit cycle.
        foreach (vecs[i]) begin
            start(vecs[i].dbuf);
            go_to(vecs[i].slot * 10 + 1);
            check($sformatf("blank_sel[%0d]", i), sel, 6'h3F);
            check($sformatf("blank_seg[%0d]", i), seg, 8'hFF);
            go_to(vecs[i].slot * 10 + 2);
            check($sformatf("show_sel[%0d]", i), sel, vecs[i].exp_sel);
            check($sformatf("show_seg[%0d]", i), seg, vecs[i].exp_seg);
            go_to(vecs[i].slot * 10 + 9);
            check($sformatf("last_sel[%0d]", i), sel, vecs[i].exp_sel);
            check($sformatf("last_seg[%0d]", i), seg, vecs[i].exp_seg);
        end

        // Buffer change mid-frame must not tear the current frame.
        start(24'h000000);
        go_to(30);
        dispbuf = 24'h999999;
        go_to(32);
        check("tear_d3", seg, 8'hC0);
        go_to(42);
        check("tear_d4", seg, 8'h40);
        go_to(52);
        check("tear_d5", seg, 8'hC0);
        go_to(59);
        check("tear_no_tick", frame_tick, 1'b0);
        go_to(60);
        check("tear_tick", frame_tick, 1'b1);
        go_to(62);
        check("new_d0", seg, 8'h90);
        go_to(102);
        check("new_d4", seg, 8'h10);

        // Reset pulse mid-slot (idx=4, cnt=6) restarts with a fresh snapshot.
        start(24'h123456);
        go_to(45);
        check("pre_rst_sel", sel, 6'h2F);
        check("pre_rst_seg", seg, 8'h24);
        rst     = 1'b1;
        dispbuf = 24'h654321;
        @(posedge clk_50Mhz);
        #1;
        check("midrst_sel", sel, 6'h3F);
        check("midrst_seg", seg, 8'hFF);
        check("midrst_tick", frame_tick, 1'b0);
        rst   = 1'b0;
        n_cur = -1;
        go_to(0);
        check("rst_tick", frame_tick, 1'b1);
        check("rst_blank0", sel, 6'h3F);
        go_to(1);
        check("rst_blank1", sel, 6'h3F);
        go_to(2);
        check("rst_sel0", sel, 6'h3E);
        check("rst_seg0", seg, 8'hF9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
